// File: rtl/conv2d_pkg.sv
// Shared FSM state type and counter sizing helper for the conv2d window generator.
package conv2d_pkg;

  typedef enum logic [1:0] {IDLE, FILL, STREAM} state_t;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv2d_line_buf.sv
// One image row of pixels: combinational read, synchronous write, so a same-address
// access returns the old contents (read-before-write).
module conv2d_line_buf
  import conv2d_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int IN_CH  = 16,
  parameter int IMG_W  = 32,
  parameter int AW     = cnt_w(IMG_W)
) (
  input  logic                           clk,
  input  logic                           wr_en,
  input  logic [AW-1:0]                  addr,
  input  logic [IN_CH-1:0][DATA_W-1:0]   wr_data,
  output logic [IN_CH-1:0][DATA_W-1:0]   rd_data
);

  logic [IN_CH-1:0][DATA_W-1:0] mem [IMG_W];

  assign rd_data = mem[addr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[addr] <= wr_data;
  end

endmodule

// File: rtl/conv2d_window_gen.sv
// Raster-stream KxK sliding-window generator ("valid" convolution, no padding).
// K-1 line buffers cascade older rows; a KxK shift register presents the window.
module conv2d_window_gen
  import conv2d_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int IN_CH  = 16,
  parameter int K      = 3,
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          in_valid,
  output logic                                          in_ready,
  input  logic                                          in_sof,
  input  logic [IN_CH-1:0][DATA_W-1:0]                  in_pix,
  output logic [K-1:0][K-1:0][IN_CH-1:0][DATA_W-1:0]    window,
  output logic                                          win_valid,
  input  logic                                          win_ready,
  output logic                                          frame_done
);

  localparam int CW = cnt_w(IMG_W);
  localparam int RW = cnt_w(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [CW-1:0] COL_KM1  = CW'(K - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_KM1  = RW'(K - 1);

  typedef logic [IN_CH-1:0][DATA_W-1:0] pix_t;

  logic [CW-1:0] col, pos_col;
  logic [RW-1:0] row, pos_row;
  logic          acc, hs, qualify, last_pix, win_last, streaming;
  state_t        state, state_nxt;
  pix_t          rd [K-1];

  assign in_ready = !(win_valid && !win_ready);
  assign acc      = in_valid && in_ready;
  assign hs       = win_valid && win_ready;
  // A start-of-frame pixel is placed at (0,0) regardless of where the counters are.
  assign pos_col  = in_sof ? '0 : col;
  assign pos_row  = in_sof ? '0 : row;
  assign qualify  = acc && (pos_row >= ROW_KM1) && (pos_col >= COL_KM1);
  assign last_pix = (pos_row == ROW_LAST) && (pos_col == COL_LAST);

  for (genvar i = 0; i < K - 1; i++) begin : g_lb
    pix_t wr_data;
    if (i == 0) begin : g_head
      assign wr_data = in_pix;
    end else begin : g_tail
      assign wr_data = rd[i-1];
    end
    conv2d_line_buf #(
      .DATA_W(DATA_W), .IN_CH(IN_CH), .IMG_W(IMG_W), .AW(CW)
    ) u_lb (
      .clk     (clk),
      .wr_en   (acc),
      .addr    (pos_col),
      .wr_data (wr_data),
      .rd_data (rd[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (acc) begin
      if (pos_col == COL_LAST) begin
        col <= '0;
        row <= (pos_row == ROW_LAST) ? '0 : pos_row + 1'b1;
      end else begin
        col <= pos_col + 1'b1;
        row <= pos_row;
      end
    end
  end

  // Window stage: column shift on every accepted pixel, new right column from line buffers.
  always_ff @(posedge clk) begin
    if (rst) begin
      window <= '0;
    end else if (acc) begin
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K - 1; c++)
          window[r][c] <= window[r][c+1];
      for (int r = 0; r < K - 1; r++)
        window[r][K-1] <= rd[K-2-r];
      window[K-1][K-1] <= in_pix;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win_valid  <= 1'b0;
      win_last   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= hs && win_last;
      if (qualify) begin
        win_valid <= 1'b1;
        win_last  <= last_pix;
      end else if (hs) begin
        win_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (acc && in_sof) begin
      state_nxt = FILL;
    end else begin
      case (state)
        IDLE:    if (acc) state_nxt = FILL;
        FILL:    if (row >= ROW_KM1) state_nxt = STREAM;
        STREAM:  if (acc && last_pix) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    streaming = (state == STREAM);
  end

  a_valid_only_streaming: assert property (@(posedge clk) disable iff (rst) qualify |-> streaming);

endmodule

// File: tb/tb_conv2d_window_gen.sv
// Scoreboard bench for conv2d_window_gen: a 5x4 image instance and a 3x3 image instance.
module tb_conv2d_window_gen;

  localparam int DATA_W = 8;
  localparam int IN_CH  = 2;
  localparam int K      = 3;

  typedef logic [IN_CH-1:0][DATA_W-1:0] pix_t;
  typedef logic [K-1:0][K-1:0][IN_CH-1:0][DATA_W-1:0] win_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic a_rst, a_in_valid, a_in_ready, a_in_sof, a_win_valid, a_win_ready, a_frame_done;
  logic b_rst, b_in_valid, b_in_ready, b_in_sof, b_win_valid, b_win_ready, b_frame_done;
  pix_t a_in_pix, b_in_pix;
  win_t a_window, b_window;

  conv2d_window_gen #(.DATA_W(DATA_W), .IN_CH(IN_CH), .K(K), .IMG_W(5), .IMG_H(4)) dut_a (
    .clk(clk), .rst(a_rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_sof(a_in_sof),
    .in_pix(a_in_pix), .window(a_window), .win_valid(a_win_valid), .win_ready(a_win_ready),
    .frame_done(a_frame_done)
  );

  conv2d_window_gen #(.DATA_W(DATA_W), .IN_CH(IN_CH), .K(K), .IMG_W(3), .IMG_H(3)) dut_b (
    .clk(clk), .rst(b_rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_sof(b_in_sof),
    .in_pix(b_in_pix), .window(b_window), .win_valid(b_win_valid), .win_ready(b_win_ready),
    .frame_done(b_frame_done)
  );

  int   n_asrt = 0;
  int   n_fail = 0;
  int   fd_cnt = 0;
  bit   sel_b  = 1'b0;
  win_t exp_q[$];
  win_t obs_q[$];

  function automatic pix_t mkpix(input int r, input int c);
    pix_t p;
    logic [7:0] v;
    v = 8'(r * 16 + c);
    p[0] = v;
    p[1] = ~v;
    return p;
  endfunction

  function automatic win_t mkwin(input int r, input int c);
    win_t w;
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++)
        w[i][j] = mkpix(r - (K - 1) + i, c - (K - 1) + j);
    return w;
  endfunction

  // Monitor: records every accepted window and frame_done pulse of the selected DUT.
  always @(negedge clk) begin
    if (!sel_b) begin
      if (a_win_valid && a_win_ready) obs_q.push_back(a_window);
      if (a_frame_done) fd_cnt++;
    end else begin
      if (b_win_valid && b_win_ready) obs_q.push_back(b_window);
      if (b_frame_done) fd_cnt++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required test completion");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Offers one pixel (bounded wait), and pushes the expected window when it qualifies.
  task automatic send_pix(input bit b, input int r, input int c, input bit sof);
    int waited;
    waited = 0;
    if (b) begin b_in_valid = 1'b1; b_in_sof = sof; b_in_pix = mkpix(r, c); end
    else   begin a_in_valid = 1'b1; a_in_sof = sof; a_in_pix = mkpix(r, c); end
    @(negedge clk);
    while (!(b ? b_in_ready : a_in_ready) && waited < 20) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      waited++;
    end
    n_asrt++;
    if (!(b ? b_in_ready : a_in_ready)) begin
      n_fail++;
      $display("FAIL accept_timeout pixel (%0d,%0d): in_ready=0, required 1", r, c);
    end
    if (r >= K - 1 && c >= K - 1) exp_q.push_back(mkwin(r, c));
    @(posedge clk);
    #1;
    if (b) begin b_in_valid = 1'b0; b_in_sof = 1'b0; end
    else   begin a_in_valid = 1'b0; a_in_sof = 1'b0; end
  endtask

  task automatic test_reset();
    a_rst = 1'b1; b_rst = 1'b1;
    idle(2);
    a_rst = 1'b0; b_rst = 1'b0;
    n_asrt++; if (a_win_valid !== 1'b0) begin n_fail++; $display("FAIL reset_a_win_valid: got %b, required 0", a_win_valid); end
    n_asrt++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_a_in_ready: got %b, required 1", a_in_ready); end
    n_asrt++; if (a_frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_a_frame_done: got %b, required 0", a_frame_done); end
    n_asrt++; if (a_window !== '0) begin n_fail++; $display("FAIL reset_a_window: got %h, required 0", a_window); end
    n_asrt++; if (b_win_valid !== 1'b0) begin n_fail++; $display("FAIL reset_b_win_valid: got %b, required 0", b_win_valid); end
    n_asrt++; if (b_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_b_in_ready: got %b, required 1", b_in_ready); end
    n_asrt++; if (b_window !== '0) begin n_fail++; $display("FAIL reset_b_window: got %h, required 0", b_window); end
  endtask

  task automatic test_full_frame();
    int   fd0;
    win_t e, o;
    fd0 = fd_cnt;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 5; c++) begin
        send_pix(1'b0, r, c, (r == 0 && c == 0));
        if (r == 2 && c == 1) begin
          n_asrt++; if (a_win_valid !== 1'b0) begin n_fail++; $display("FAIL full_early_valid: got %b, required 0", a_win_valid); end
        end
        if (r == 2 && c == 2) begin
          n_asrt++; if (a_win_valid !== 1'b1) begin n_fail++; $display("FAIL full_first_valid: got %b, required 1", a_win_valid); end
          n_asrt++; if (a_window[0][0] !== mkpix(0, 0)) begin n_fail++; $display("FAIL full_first_w00: got %h, required %h", a_window[0][0], mkpix(0, 0)); end
          n_asrt++; if (a_window[2][2][0] !== 8'h22) begin n_fail++; $display("FAIL full_first_w22: got %h, required 22", a_window[2][2][0]); end
        end
      end
    n_asrt++; if (a_frame_done !== 1'b0) begin n_fail++; $display("FAIL full_fd_early: got %b, required 0", a_frame_done); end
    idle(1);
    n_asrt++; if (a_frame_done !== 1'b1) begin n_fail++; $display("FAIL full_fd_pulse: got %b, required 1", a_frame_done); end
    idle(1);
    n_asrt++; if (a_frame_done !== 1'b0) begin n_fail++; $display("FAIL full_fd_width: got %b, required 0", a_frame_done); end
    idle(3);
    n_asrt++; if (obs_q.size() != 6) begin n_fail++; $display("FAIL full_count: windows %0d, required 6", obs_q.size()); end
    if (obs_q.size() > 0) begin
      o = obs_q[obs_q.size() - 1];
      n_asrt++; if (o[0][0][0] !== 8'h12 || o[2][2][0] !== 8'h34) begin n_fail++; $display("FAIL full_last: w00=%h w22=%h, required 12 34", o[0][0][0], o[2][2][0]); end
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_asrt++; if (o !== e) begin n_fail++; $display("FAIL full_win: got %h, required %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
    n_asrt++; if (fd_cnt - fd0 != 1) begin n_fail++; $display("FAIL full_fd_count: got %0d, required 1", fd_cnt - fd0); end
  endtask

  task automatic test_stall();
    int   fd0;
    win_t e, o;
    fd0 = fd_cnt;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 5; c++) begin
        if (r == 2 && c == 4) begin
          a_win_ready = 1'b0; a_in_valid = 1'b1; a_in_pix = mkpix(2, 4);
          for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_asrt++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready cycle %0d: got %b, required 0", k, a_in_ready); end
            n_asrt++; if (a_win_valid !== 1'b1 || a_window !== mkwin(2, 3)) begin n_fail++; $display("FAIL stall_window cycle %0d: valid %b win %h, required 1 %h", k, a_win_valid, a_window, mkwin(2, 3)); end
            @(posedge clk);
            #1;
          end
          a_win_ready = 1'b1;
        end
        send_pix(1'b0, r, c, (r == 0 && c == 0));
      end
    idle(4);
    n_asrt++; if (obs_q.size() != 6) begin n_fail++; $display("FAIL stall_count: windows %0d, required 6", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_asrt++; if (o !== e) begin n_fail++; $display("FAIL stall_win: got %h, required %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
    n_asrt++; if (fd_cnt - fd0 != 1) begin n_fail++; $display("FAIL stall_fd_count: got %0d, required 1", fd_cnt - fd0); end
  endtask

  task automatic test_random_gaps();
    int   fd0, g;
    win_t e, o;
    fd0 = fd_cnt;
    for (int f = 0; f < 2; f++)
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 5; c++) begin
          g = 0;
          while ($urandom_range(0, 1) == 1 && g < 4) begin idle(1); g++; end
          send_pix(1'b0, r, c, (f == 0 && r == 0 && c == 0));
        end
    idle(4);
    n_asrt++; if (obs_q.size() != 12) begin n_fail++; $display("FAIL gaps_count: windows %0d, required 12", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_asrt++; if (o !== e) begin n_fail++; $display("FAIL gaps_win: got %h, required %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
    n_asrt++; if (fd_cnt - fd0 != 2) begin n_fail++; $display("FAIL gaps_fd_count: got %0d, required 2", fd_cnt - fd0); end
  endtask

  task automatic test_sof_abort();
    int   fd0;
    win_t e, o;
    fd0 = fd_cnt;
    for (int c = 0; c < 5; c++) send_pix(1'b0, 0, c, (c == 0));
    for (int c = 0; c < 2; c++) send_pix(1'b0, 1, c, 1'b0);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 5; c++)
        send_pix(1'b0, r, c, (r == 0 && c == 0));
    idle(4);
    n_asrt++; if (obs_q.size() != 6) begin n_fail++; $display("FAIL sof_count: windows %0d, required 6", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_asrt++; if (o !== e) begin n_fail++; $display("FAIL sof_win: got %h, required %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
    n_asrt++; if (fd_cnt - fd0 != 1) begin n_fail++; $display("FAIL sof_fd_count: got %0d, required 1", fd_cnt - fd0); end
  endtask

  task automatic test_mid_reset();
    int   fd0;
    win_t e, o;
    fd0 = fd_cnt;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 5; c++)
        if (r < 2 || c < 3) send_pix(1'b0, r, c, (r == 0 && c == 0));
    a_rst = 1'b1; a_in_valid = 1'b1; a_in_pix = mkpix(2, 3);
    idle(1);
    a_rst = 1'b0; a_in_valid = 1'b0;
    n_asrt++; if (a_win_valid !== 1'b0) begin n_fail++; $display("FAIL mrst_win_valid: got %b, required 0", a_win_valid); end
    n_asrt++; if (a_window !== '0) begin n_fail++; $display("FAIL mrst_window: got %h, required 0", a_window); end
    n_asrt++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL mrst_in_ready: got %b, required 1", a_in_ready); end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 5; c++)
        send_pix(1'b0, r, c, 1'b0);
    idle(4);
    n_asrt++; if (obs_q.size() != 7) begin n_fail++; $display("FAIL mrst_count: windows %0d, required 7", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_asrt++; if (o !== e) begin n_fail++; $display("FAIL mrst_win: got %h, required %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
    n_asrt++; if (fd_cnt - fd0 != 1) begin n_fail++; $display("FAIL mrst_fd_count: got %0d, required 1", fd_cnt - fd0); end
  endtask

  task automatic test_small_image();
    int   fd0;
    win_t e, o;
    sel_b = 1'b1;
    idle(1);
    fd0 = fd_cnt;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        send_pix(1'b1, r, c, (r == 0 && c == 0));
        if (r == 2 && c == 1) begin
          n_asrt++; if (b_win_valid !== 1'b0) begin n_fail++; $display("FAIL small_early_valid: got %b, required 0", b_win_valid); end
        end
      end
    n_asrt++; if (b_win_valid !== 1'b1 || b_window !== mkwin(2, 2)) begin n_fail++; $display("FAIL small_window: valid %b win %h, required 1 %h", b_win_valid, b_window, mkwin(2, 2)); end
    idle(1);
    n_asrt++; if (b_frame_done !== 1'b1) begin n_fail++; $display("FAIL small_fd_pulse: got %b, required 1", b_frame_done); end
    idle(3);
    n_asrt++; if (obs_q.size() != 1) begin n_fail++; $display("FAIL small_count: windows %0d, required 1", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_asrt++; if (o !== e) begin n_fail++; $display("FAIL small_win: got %h, required %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
    n_asrt++; if (fd_cnt - fd0 != 1) begin n_fail++; $display("FAIL small_fd_count: got %0d, required 1", fd_cnt - fd0); end
  endtask

  initial begin
    a_rst = 1'b1; a_in_valid = 1'b0; a_in_sof = 1'b0; a_in_pix = '0; a_win_ready = 1'b1;
    b_rst = 1'b1; b_in_valid = 1'b0; b_in_sof = 1'b0; b_in_pix = '0; b_win_ready = 1'b1;
    test_reset();
    test_full_frame();
    test_stall();
    test_random_gaps();
    test_sof_abort();
    test_mid_reset();
    test_small_image();
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
